boreal_sram_arb: RTL and testbench

Round-robin arbiter that shares one single-port word SRAM between NUM_REQ requesters, such as the vector engine read port, the vector engine write port and the CPU data port. Each requester uses a hold-until-ack protocol: it raises req with stable address and data and waits for a one-cycle ack. The block serialises accesses, applies the fixed SRAM read latency, returns read data and flags out-of-range addresses. It sits between the vector engine / CPU fabric and the SRAM macro.

---
 rtl/boreal_sram_arb.sv | 229 ++++++++++++++++++++++
 tb/tb_boreal_sram_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_sram_arb.sv
// ---------------------------------------------------------------------------
// boreal_sram_arb
//
// Round-robin arbiter sharing one single-port word SRAM between NUM_REQ
// requesters (vector engine read/write ports, CPU data port, ...). Each
// requester holds req with stable address/data until it sees a one-cycle ack.
// Accesses are serialised through IDLE -> ISSUE -> (WAIT) -> RESP, the fixed
// SRAM read latency is absorbed in WAIT, and out-of-range byte addresses are
// answered with ERR_DATA plus an err pulse without touching the SRAM.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             per-requester request, held until ack
//   req_wr          per-requester direction (1 = write)
//   req_addr        packed byte addresses, requester i at [32*i+31:32*i]
//   req_wdata       packed write data, same packing
//   ack             one-cycle completion pulse (one-hot or zero)
//   rdata           read data, valid only while an ack bit is high
//   err             out-of-range flag, pulses together with ack
//   sram_en/we      SRAM strobe and write enable
//   sram_addr       SRAM word address (byte address bits [AW+1:2])
//   sram_wdata      SRAM write data
//   sram_rdata      SRAM read data, valid RD_LAT cycles after sram_en
//   grant_id        index of the requester being served
//   busy            high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module boreal_sram_arb #(
   parameter int          NUM_REQ  = 3,
   parameter int          AW       = 12,
   parameter int          RD_LAT   = 1,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_wr,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   ack,
   output logic [31:0]          rdata,
   output logic [NUM_REQ-1:0]   err,
   output logic                 sram_en,
   output logic                 sram_we,
   output logic [AW-1:0]        sram_addr,
   output logic [31:0]          sram_wdata,
   input  logic [31:0]          sram_rdata,
   output logic [2:0]           grant_id,
   output logic                 busy
);

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t               state_q, state_d;
   logic [2:0]           lastGrant_q, lastGrant_d;
   logic [2:0]           grant_q, grant_d;
   logic                 wr_q, wr_d;
   logic                 oor_q, oor_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 sramEn_q, sramEn_d;
   logic                 sramWe_q, sramWe_d;
   logic [AW-1:0]        sramAddr_q, sramAddr_d;
   logic [31:0]          sramWdata_q, sramWdata_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [NUM_REQ-1:0]   err_q, err_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 busy_q, busy_d;

   logic [7:0]           reqPad, wrPad;
   logic [31:0]          addrArr [8];
   logic [31:0]          wdataArr [8];
   logic [3:0]           cand;
   logic                 found;
   logic [2:0]           winner;
   logic [31:0]          selAddr;
   logic                 selOor;
   logic [NUM_REQ-1:0]   grantVec;

   // Unpack the requester buses into fixed 8-entry views so the winner can be
   // selected with a 3-bit index regardless of NUM_REQ, then search upward from
   // the requester after the last winner, wrapping around, for the first
   // pending request. The winner's range check is done here because sram_en is
   // registered on the same edge that moves the FSM into ISSUE.
   always_comb begin
      reqPad = '0;
      wrPad  = '0;
      for (int i = 0; i < 8; i++) begin
         addrArr[i]  = '0;
         wdataArr[i] = '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         reqPad[i]   = req[i];
         wrPad[i]    = req_wr[i];
         addrArr[i]  = req_addr[32*i +: 32];
         wdataArr[i] = req_wdata[32*i +: 32];
      end
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, lastGrant_q} + 4'(k);
         if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
         if (!found && reqPad[cand[2:0]]) begin
            found  = 1'b1;
            winner = cand[2:0];
         end
      end
      selAddr = addrArr[winner];
      selOor  = (selAddr >> (AW + 2)) != 32'd0;
      grantVec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grantVec[i] = (3'(i) == grant_q);
      end
   end

   // Next-state and next-output logic. Every output is registered, so the
   // values computed here are what the outputs show in the state being
   // entered: SRAM strobes are prepared in IDLE for the ISSUE cycle, and ack,
   // err and rdata are prepared on the way into RESP. Outputs default to zero
   // so they drop automatically in every other cycle.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      grant_d     = grant_q;
      wr_d        = wr_q;
      oor_d       = oor_q;
      cnt_d       = cnt_q;
      sramEn_d    = 1'b0;
      sramWe_d    = 1'b0;
      sramAddr_d  = '0;
      sramWdata_d = '0;
      ack_d       = '0;
      err_d       = '0;
      rdata_d     = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = ISSUE;
               lastGrant_d = winner;
               grant_d     = winner;
               wr_d        = wrPad[winner];
               oor_d       = selOor;
               sramEn_d    = !selOor;
               sramWe_d    = wrPad[winner] && !selOor;
               sramAddr_d  = selAddr[AW+1:2];
               sramWdata_d = wdataArr[winner];
            end
         end
         ISSUE: begin
            cnt_d = CW'(RD_LAT);
            if (oor_q) begin
               rdata_d = ERR_DATA;
               ack_d   = grantVec;
               err_d   = grantVec;
               state_d = RESP;
            end else if (wr_q) begin
               ack_d   = grantVec;
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == CW'(1)) begin
               rdata_d = sram_rdata;
               ack_d   = grantVec;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers. Reset drops any in-flight access and points
   // lastGrant at the top requester so requester 0 wins the first arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= 3'(NUM_REQ - 1);
         grant_q     <= '0;
         wr_q        <= 1'b0;
         oor_q       <= 1'b0;
         cnt_q       <= '0;
         sramEn_q    <= 1'b0;
         sramWe_q    <= 1'b0;
         sramAddr_q  <= '0;
         sramWdata_q <= '0;
         ack_q       <= '0;
         err_q       <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         grant_q     <= grant_d;
         wr_q        <= wr_d;
         oor_q       <= oor_d;
         cnt_q       <= cnt_d;
         sramEn_q    <= sramEn_d;
         sramWe_q    <= sramWe_d;
         sramAddr_q  <= sramAddr_d;
         sramWdata_q <= sramWdata_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign ack        = ack_q;
   assign err        = err_q;
   assign rdata      = rdata_q;
   assign sram_en    = sramEn_q;
   assign sram_we    = sramWe_q;
   assign sram_addr  = sramAddr_q;
   assign sram_wdata = sramWdata_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_boreal_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_boreal_sram_arb
//
// Directed bench for boreal_sram_arb. Two instances share clock and reset:
// dut with the default RD_LAT=1 and dut3 with RD_LAT=3. Each has a small
// SRAM model with the matching read latency and a backdoor preload port.
// ---------------------------------------------------------------------------
module tb_boreal_sram_arb;

   localparam int NR = 3;

   logic clk = 1'b0;
   logic rst;

   // Instance with the default read latency
   logic [NR-1:0]    req, reqWr, ack, err;
   logic [NR*32-1:0] reqAddr, reqWdata;
   logic [31:0]      rdata, sramWdata, sramRdata;
   logic             sramEn, sramWe, busy;
   logic [11:0]      sramAddr;
   logic [2:0]       grantId;

   // Instance with a three-cycle read latency
   logic [NR-1:0]    req3, reqWr3, ack3, err3;
   logic [NR*32-1:0] reqAddr3, reqWdata3;
   logic [31:0]      rdata3, sramWdata3, sramRdata3;
   logic             sramEn3, sramWe3, busy3;
   logic [11:0]      sramAddr3;
   logic [2:0]       grantId3;

   logic             bdEn;
   logic [11:0]      bdAddr;
   logic [31:0]      bdData;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   boreal_sram_arb dut (
      .clk(clk), .rst(rst), .req(req), .req_wr(reqWr), .req_addr(reqAddr),
      .req_wdata(reqWdata), .ack(ack), .rdata(rdata), .err(err),
      .sram_en(sramEn), .sram_we(sramWe), .sram_addr(sramAddr),
      .sram_wdata(sramWdata), .sram_rdata(sramRdata), .grant_id(grantId),
      .busy(busy)
   );

   boreal_sram_arb #(.RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .req_wr(reqWr3), .req_addr(reqAddr3),
      .req_wdata(reqWdata3), .ack(ack3), .rdata(rdata3), .err(err3),
      .sram_en(sramEn3), .sram_we(sramWe3), .sram_addr(sramAddr3),
      .sram_wdata(sramWdata3), .sram_rdata(sramRdata3), .grant_id(grantId3),
      .busy(busy3)
   );

   // SRAM model for dut: read data appears one cycle after sram_en is sampled
   logic [31:0] mem1 [4096];
   logic [31:0] rd1;
   always @(posedge clk) begin
      if (bdEn) mem1[bdAddr] <= bdData;
      else if (sramEn && sramWe) mem1[sramAddr] <= sramWdata;
      if (sramEn && !sramWe) rd1 <= mem1[sramAddr];
   end
   assign sramRdata = rd1;

   // SRAM model for dut3: two extra pipeline stages give a three-cycle latency
   logic [31:0] mem3 [4096];
   logic [31:0] s1, s2, rd3;
   always @(posedge clk) begin
      if (bdEn) mem3[bdAddr] <= bdData;
      else if (sramEn3 && sramWe3) mem3[sramAddr3] <= sramWdata3;
      if (sramEn3 && !sramWe3) s1 <= mem3[sramAddr3];
      s2  <= s1;
      rd3 <= s2;
   end
   assign sramRdata3 = rd3;

   // Advance to 1 ns after the next rising edge, where outputs are settled
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0; reqWr = '0; reqAddr = '0; reqWdata = '0;
      req3 = '0; reqWr3 = '0; reqAddr3 = '0; reqWdata3 = '0;
      bdEn = 1'b1; bdAddr = 12'd4; bdData = 32'h1122_3344;
      step();
      bdAddr = 12'd5; bdData = 32'h5566_7788;
      step();
      bdEn = 1'b0;
      step();
      checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 000", ack); end
      checks++; if (err !== 3'b000) begin errors++; $display("[TB] FAIL reset_err: got %b expected 000", err); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if ({sramEn, sramWe, busy} !== 3'b000) begin errors++; $display("[TB] FAIL reset_en_we_busy: got %b expected 000", {sramEn, sramWe, busy}); end
      checks++; if (grantId !== 3'd0) begin errors++; $display("[TB] FAIL reset_grant: got %0d expected 0", grantId); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_read();
      req[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[31:0] = 32'h10;
      step();
      checks++; if ({sramEn, sramWe} !== 2'b10) begin errors++; $display("[TB] FAIL read_en_c1: got %b expected 10", {sramEn, sramWe}); end
      checks++; if (sramAddr !== 12'd4) begin errors++; $display("[TB] FAIL read_addr_c1: got %h expected 004", sramAddr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL read_busy_c1: got %b expected 1", busy); end
      step();
      checks++; if ({sramEn, ack} !== 4'b0000) begin errors++; $display("[TB] FAIL read_c2: got %b expected 0000", {sramEn, ack}); end
      step();
      checks++; if (ack !== 3'b001) begin errors++; $display("[TB] FAIL read_ack_c3: got %b expected 001", ack); end
      checks++; if (rdata !== 32'h1122_3344) begin errors++; $display("[TB] FAIL read_data_c3: got %h expected 11223344", rdata); end
      checks++; if (err !== 3'b000) begin errors++; $display("[TB] FAIL read_err_c3: got %b expected 000", err); end
      req[0] = 1'b0;
      step();
      checks++; if ({ack, busy} !== 4'b0000 || rdata !== 32'h0) begin errors++; $display("[TB] FAIL read_c4_idle: got ack=%b busy=%b rdata=%h expected 000/0/0", ack, busy, rdata); end
   endtask

   task automatic test_write();
      req[1] = 1'b1; reqWr[1] = 1'b1; reqAddr[63:32] = 32'h20; reqWdata[63:32] = 32'hCAFE_F00D;
      step();
      checks++; if ({sramEn, sramWe} !== 2'b11) begin errors++; $display("[TB] FAIL write_en_we_c1: got %b expected 11", {sramEn, sramWe}); end
      checks++; if (sramAddr !== 12'd8) begin errors++; $display("[TB] FAIL write_addr_c1: got %h expected 008", sramAddr); end
      checks++; if (sramWdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL write_wdata_c1: got %h expected cafef00d", sramWdata); end
      checks++; if (grantId !== 3'd1) begin errors++; $display("[TB] FAIL write_grant_c1: got %0d expected 1", grantId); end
      step();
      checks++; if (ack !== 3'b010) begin errors++; $display("[TB] FAIL write_ack_c2: got %b expected 010", ack); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL write_rdata_c2: got %h expected 0", rdata); end
      req[1] = 1'b0; reqWr[1] = 1'b0;
      step();
      // Read the word back through requester 0
      req[0] = 1'b1; reqAddr[31:0] = 32'h20;
      step(); step(); step();
      checks++; if (ack !== 3'b001 || rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL write_readback: got ack=%b rdata=%h expected 001/cafef00d", ack, rdata); end
      req[0] = 1'b0;
      step();
   endtask

   task automatic test_out_of_range();
      req[2] = 1'b1; reqWr[2] = 1'b0; reqAddr[95:64] = 32'h0001_0000;
      step();
      checks++; if ({sramEn, busy} !== 2'b01) begin errors++; $display("[TB] FAIL oor_c1: got en,busy=%b expected 01", {sramEn, busy}); end
      step();
      checks++; if (ack !== 3'b100 || err !== 3'b100) begin errors++; $display("[TB] FAIL oor_ack_err_c2: got ack=%b err=%b expected 100/100", ack, err); end
      checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL oor_rdata_c2: got %h expected deadbeef", rdata); end
      checks++; if (sramEn !== 1'b0) begin errors++; $display("[TB] FAIL oor_en_c2: got %b expected 0", sramEn); end
      req[2] = 1'b0;
      step();
      checks++; if ({ack, err} !== 6'b0) begin errors++; $display("[TB] FAIL oor_c3_clear: got %b expected 000000", {ack, err}); end
   endtask

   task automatic test_round_robin();
      int order [6];
      int got = 0;
      bit prevAck = 1'b0;
      for (int i = 0; i < 6; i++) order[i] = 7;
      rst = 1'b1;
      reqWr = 3'b111;
      reqAddr = {32'h108, 32'h104, 32'h100};
      reqWdata = {32'hA2, 32'hA1, 32'hA0};
      req = 3'b111;
      step();
      rst = 1'b0;
      for (int c = 0; c < 60 && (got < 6 || prevAck); c++) begin
         step();
         if (prevAck) begin
            checks++; if ({ack, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL rr_idle_gap: got ack=%b busy=%b expected 000/0", ack, busy); end
            prevAck = 1'b0;
         end else if (ack !== 3'b000) begin
            case (ack)
               3'b001:  order[got] = 0;
               3'b010:  order[got] = 1;
               3'b100:  order[got] = 2;
               default: order[got] = 9;
            endcase
            got++;
            prevAck = 1'b1;
            if (got == 6) req = '0;
         end
      end
      req = '0; reqWr = '0;
      checks++; if (got !== 6) begin errors++; $display("[TB] FAIL rr_ack_count: got %0d expected 6", got); end
      for (int i = 0; i < 6; i++) begin
         checks++; if (order[i] !== i % 3) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % 3); end
      end
      step();
   endtask

   task automatic test_reset_during_wait();
      int got = 0;
      req[0] = 1'b1; reqAddr[31:0] = 32'h10;
      step();
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstw_busy_wait: got %b expected 1", busy); end
      req[1] = 1'b1; reqAddr[63:32] = 32'h20;
      rst = 1'b1;
      #1;
      checks++; if ({ack, err, sramEn, sramWe, busy} !== 9'b0 || rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstw_outputs: got ack=%b busy=%b en=%b rdata=%h expected all 0", ack, busy, sramEn, rdata); end
      step();
      checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL rstw_no_ack: got %b expected 000", ack); end
      rst = 1'b0;
      // Both req0 and req1 are pending; req0 must be served first
      for (int c = 0; c < 20 && got < 2; c++) begin
         step();
         if (ack !== 3'b000) begin
            if (got == 0) begin
               checks++; if (ack !== 3'b001 || rdata !== 32'h1122_3344) begin errors++; $display("[TB] FAIL rstw_first: got ack=%b rdata=%h expected 001/11223344", ack, rdata); end
               req[0] = 1'b0;
            end else begin
               checks++; if (ack !== 3'b010 || rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL rstw_second: got ack=%b rdata=%h expected 010/cafef00d", ack, rdata); end
               req[1] = 1'b0;
            end
            got++;
         end
      end
      checks++; if (got !== 2) begin errors++; $display("[TB] FAIL rstw_ack_count: got %0d expected 2", got); end
      req = '0;
      step();
   endtask

   task automatic test_rdlat3();
      req3[0] = 1'b1; reqWr3[0] = 1'b0; reqAddr3[31:0] = 32'h14;
      step();
      checks++; if (sramEn3 !== 1'b1 || sramAddr3 !== 12'd5) begin errors++; $display("[TB] FAIL lat3_c1: got en=%b addr=%h expected 1/005", sramEn3, sramAddr3); end
      step();
      req3[0] = 1'b0;
      step();
      checks++; if (ack3 !== 3'b000) begin errors++; $display("[TB] FAIL lat3_c3_noack: got %b expected 000", ack3); end
      step();
      checks++; if (ack3 !== 3'b000) begin errors++; $display("[TB] FAIL lat3_c4_noack: got %b expected 000", ack3); end
      step();
      checks++; if (ack3 !== 3'b001 || rdata3 !== 32'h5566_7788) begin errors++; $display("[TB] FAIL lat3_c5_ack: got ack=%b rdata=%h expected 001/55667788", ack3, rdata3); end
      step();
      checks++; if (ack3 !== 3'b000 || busy3 !== 1'b0) begin errors++; $display("[TB] FAIL lat3_c6_idle: got ack=%b busy=%b expected 000/0", ack3, busy3); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_out_of_range();
      test_round_robin();
      test_reset_during_wait();
      test_rdlat3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
